// File: rtl/grayscale_convert.sv
// In-place BGR-to-luma conversion of a 24-bit BMP held in byte-wide RAM.
// Each pixel is read (B,G,R), converted, then written back to all three bytes.
module grayscale_convert #(
    parameter int BYTE_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 20,
    parameter int BMP_HEADER_SIZE = 54,
    parameter int BMP_TOTAL_SIZE  = 786486
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [BYTE_WIDTH-1:0] RAM_out,
    output logic                  RAM_ren,
    output logic                  RAM_wen,
    output logic [BYTE_WIDTH-1:0] RAM_in,
    output logic [ADDR_WIDTH-1:0] RAM_addr,
    output logic                  gray_done,
    output logic                  busy
);

    localparam int SumWidth = 2 * BYTE_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LastStart  = (ADDR_WIDTH + 1)'(BMP_TOTAL_SIZE - 3);
    localparam logic [ADDR_WIDTH-1:0] HeaderAddr = ADDR_WIDTH'(BMP_HEADER_SIZE);

    typedef enum logic [3:0] {
        StIdle, StRdB, StRdG, StRdR, StCalc, StWrB, StWrG, StWrR, StDone
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [BYTE_WIDTH-1:0] b_q, b_d, g_q, g_d, r_q, r_d, gray_q, gray_d;
    logic                  ren_q, ren_d, wen_q, wen_d;
    logic [BYTE_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  done_q, done_d, busy_q, busy_d;
    logic [SumWidth-1:0]   sum;
    logic [ADDR_WIDTH:0]   ptr_next;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        b_d      = b_q;
        g_d      = g_q;
        r_d      = r_q;
        gray_d   = gray_q;
        sum      = SumWidth'(77) * SumWidth'(r_q) + SumWidth'(150) * SumWidth'(g_q)
                 + SumWidth'(29) * SumWidth'(b_q);
        ptr_next = {1'b0, ptr_q} + (ADDR_WIDTH + 1)'(3);

        unique case (state_q)
            StIdle:  if (in_valid) state_d = StRdB;
            StRdB:   begin b_d = RAM_out; state_d = StRdG; end
            StRdG:   begin g_d = RAM_out; state_d = StRdR; end
            StRdR:   begin r_d = RAM_out; state_d = StCalc; end
            StCalc:  begin gray_d = sum[SumWidth-1:BYTE_WIDTH]; state_d = StWrB; end
            StWrB:   state_d = StWrG;
            StWrG:   state_d = StWrR;
            StWrR: begin
                ptr_d   = ptr_next[ADDR_WIDTH-1:0];
                // Stop once a full 3-byte pixel no longer fits before the end of file.
                state_d = (ptr_next > LastStart) ? StDone : StRdB;
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        wdata_d = '0;
        addr_d  = '0;
        unique case (state_d)
            StRdB: begin ren_d = 1'b1; addr_d = ptr_d; end
            StRdG: begin ren_d = 1'b1; addr_d = ptr_d + ADDR_WIDTH'(1); end
            StRdR: begin ren_d = 1'b1; addr_d = ptr_d + ADDR_WIDTH'(2); end
            StWrB: begin wen_d = 1'b1; wdata_d = gray_d; addr_d = ptr_d; end
            StWrG: begin wen_d = 1'b1; wdata_d = gray_d; addr_d = ptr_d + ADDR_WIDTH'(1); end
            StWrR: begin wen_d = 1'b1; wdata_d = gray_d; addr_d = ptr_d + ADDR_WIDTH'(2); end
            default: ;
        endcase
        busy_d = (state_d != StIdle) && (state_d != StDone);
        done_d = done_q || (state_q == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= HeaderAddr;
            b_q     <= '0;
            g_q     <= '0;
            r_q     <= '0;
            gray_q  <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            b_q     <= b_d;
            g_q     <= g_d;
            r_q     <= r_d;
            gray_q  <= gray_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign RAM_ren   = ren_q;
    assign RAM_wen   = wen_q;
    assign RAM_in    = wdata_q;
    assign RAM_addr  = addr_q;
    assign gray_done = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_grayscale_convert.sv
// Directed bench for grayscale_convert: three small images (2 pixels, 2 pixels plus
// 2 trailing bytes, 4 pixels) each on its own instance with a behavioural RAM.
module tb_grayscale_convert;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] img [0:15];
    int         n_checks = 0;
    int         n_fail   = 0;

    logic        iv_a, ld_a, ren_a, wen_a, done_a, busy_a;
    logic [7:0]  din_a, dout_a;
    logic [19:0] addr_a;
    logic [7:0]  mem_a [0:15];
    logic        iv_b, ld_b, ren_b, wen_b, done_b, busy_b;
    logic [7:0]  din_b, dout_b;
    logic [19:0] addr_b;
    logic [7:0]  mem_b [0:15];
    logic        iv_c, ld_c, ren_c, wen_c, done_c, busy_c;
    logic [7:0]  din_c, dout_c;
    logic [19:0] addr_c;
    logic [7:0]  mem_c [0:15];

    grayscale_convert #(.BYTE_WIDTH(8), .ADDR_WIDTH(20), .BMP_HEADER_SIZE(4),
                        .BMP_TOTAL_SIZE(10)) u_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .RAM_out(dout_a), .RAM_ren(ren_a),
        .RAM_wen(wen_a), .RAM_in(din_a), .RAM_addr(addr_a), .gray_done(done_a), .busy(busy_a));
    grayscale_convert #(.BYTE_WIDTH(8), .ADDR_WIDTH(20), .BMP_HEADER_SIZE(4),
                        .BMP_TOTAL_SIZE(12)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .RAM_out(dout_b), .RAM_ren(ren_b),
        .RAM_wen(wen_b), .RAM_in(din_b), .RAM_addr(addr_b), .gray_done(done_b), .busy(busy_b));
    grayscale_convert #(.BYTE_WIDTH(8), .ADDR_WIDTH(20), .BMP_HEADER_SIZE(4),
                        .BMP_TOTAL_SIZE(16)) u_c (
        .clk(clk), .rst(rst), .in_valid(iv_c), .RAM_out(dout_c), .RAM_ren(ren_c),
        .RAM_wen(wen_c), .RAM_in(din_c), .RAM_addr(addr_c), .gray_done(done_c), .busy(busy_c));

    assign dout_a = mem_a[addr_a[3:0]];
    assign dout_b = mem_b[addr_b[3:0]];
    assign dout_c = mem_c[addr_c[3:0]];

    always @(posedge clk) begin
        if (ld_a) for (int i = 0; i < 16; i++) mem_a[i] <= img[i];
        else if (wen_a) mem_a[addr_a[3:0]] <= din_a;
        if (ld_b) for (int i = 0; i < 16; i++) mem_b[i] <= img[i];
        else if (wen_b) mem_b[addr_b[3:0]] <= din_b;
        if (ld_c) for (int i = 0; i < 16; i++) mem_c[i] <= img[i];
        else if (wen_c) mem_c[addr_c[3:0]] <= din_c;
    end

    function automatic logic [7:0] bg(input int i);
        return 8'(8'hA0 + i);
    endfunction

    task automatic fill_bg();
        for (int i = 0; i < 16; i++) img[i] = bg(i);
    endtask

    task automatic load(input int which);
        @(negedge clk);
        ld_a = (which == 0);
        ld_b = (which == 1);
        ld_c = (which == 2);
        @(negedge clk);
        ld_a = 1'b0; ld_b = 1'b0; ld_c = 1'b0;
    endtask

    // Raises in_valid for one sample edge and counts edges until gray_done is seen.
    task automatic run_and_time(input int which, output int n);
        logic d;
        @(negedge clk);
        if (which == 0) iv_a = 1'b1; else if (which == 1) iv_b = 1'b1; else iv_c = 1'b1;
        @(posedge clk);
        #1;
        iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
        n = 0;
        d = 1'b0;
        while (!d && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_checks++;
        if ({ren_a, wen_a, din_a, addr_a, done_a, busy_a} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_a: got ren=%0d wen=%0d in=%0d addr=%0d done=%0d busy=%0d required all 0",
                     ren_a, wen_a, din_a, addr_a, done_a, busy_a);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ren_b, wen_b, addr_b, done_b, busy_b, ren_c, wen_c, done_c, busy_c} !== 28'd0) begin
            n_fail++;
            $display("FAIL idle_outputs: got ren_b=%0d wen_b=%0d addr_b=%0d busy_b=%0d busy_c=%0d required all 0",
                     ren_b, wen_b, addr_b, busy_b, busy_c);
        end
    endtask

    task automatic test_small_image();
        int n;
        logic [7:0] exp;
        fill_bg();
        img[4] = 8'd100; img[5] = 8'd150; img[6] = 8'd200;
        img[7] = 8'd255; img[8] = 8'd255; img[9] = 8'd255;
        load(0);
        run_and_time(0, n);
        n_checks++;
        if (n !== 15) begin
            n_fail++;
            $display("FAIL small_done_latency: got %0d cycles required 15", n);
        end
        for (int i = 0; i < 10; i++) begin
            exp = (i < 4) ? bg(i) : (i < 7) ? 8'd159 : 8'd255;
            n_checks++;
            if (mem_a[i] !== exp) begin
                n_fail++;
                $display("FAIL small_byte%0d: got %0d required %0d", i, mem_a[i], exp);
            end
        end
    endtask

    task automatic test_non_multiple();
        int n;
        logic [7:0] exp;
        fill_bg();
        img[4] = 8'd10;  img[5] = 8'd20;  img[6] = 8'd30;
        img[7] = 8'd200; img[8] = 8'd100; img[9] = 8'd50;
        load(1);
        run_and_time(1, n);
        n_checks++;
        if (n !== 15) begin
            n_fail++;
            $display("FAIL nonmult_done_latency: got %0d cycles required 15", n);
        end
        for (int i = 0; i < 12; i++) begin
            exp = (i < 4 || i > 9) ? bg(i) : (i < 7) ? 8'd21 : 8'd96;
            n_checks++;
            if (mem_b[i] !== exp) begin
                n_fail++;
                $display("FAIL nonmult_byte%0d: got %0d required %0d", i, mem_b[i], exp);
            end
        end
    endtask

    task automatic test_protocol();
        int q[$];
        int n;
        int exp;
        fill_bg();
        img[4]  = 8'd0;   img[5]  = 8'd0;   img[6]  = 8'd255;
        img[7]  = 8'd0;   img[8]  = 8'd255; img[9]  = 8'd0;
        img[10] = 8'd255; img[11] = 8'd0;   img[12] = 8'd0;
        img[13] = 8'd0;   img[14] = 8'd0;   img[15] = 8'd0;
        load(2);
        @(negedge clk);
        iv_c = 1'b1;
        @(posedge clk);
        #1;
        iv_c = 1'b0;
        n = 0;
        while (!done_c && n < 200) begin
            n_checks++;
            if (ren_c && wen_c) begin
                n_fail++;
                $display("FAIL proto_ren_wen: got both high at addr %0d required exclusive", addr_c);
            end
            n_checks++;
            if ((ren_c || wen_c) && addr_c < 20'd4) begin
                n_fail++;
                $display("FAIL proto_header: got access at %0d required >= 4", addr_c);
            end
            n_checks++;
            if (!busy_c && addr_c !== 20'd0) begin
                n_fail++;
                $display("FAIL proto_idle_addr: got %0d required 0", addr_c);
            end
            if (ren_c || wen_c) q.push_back(int'(wen_c) * 1000 + int'(addr_c));
            @(posedge clk);
            n++;
            #1;
        end
        n_checks++;
        if (n !== 29) begin
            n_fail++;
            $display("FAIL proto_done_latency: got %0d cycles required 29", n);
        end
        n_checks++;
        if (q.size() !== 24) begin
            n_fail++;
            $display("FAIL proto_access_count: got %0d required 24", q.size());
        end else begin
            for (int p = 0; p < 4; p++) begin
                for (int k = 0; k < 6; k++) begin
                    exp = (k < 3) ? (4 + 3 * p + k) : (1000 + 4 + 3 * p + k - 3);
                    n_checks++;
                    if (q[p * 6 + k] !== exp) begin
                        n_fail++;
                        $display("FAIL proto_seq%0d: got %0d required %0d", p * 6 + k,
                                 q[p * 6 + k], exp);
                    end
                end
            end
        end
        n_checks++;
        if (addr_c !== 20'd0 || busy_c !== 1'b0) begin
            n_fail++;
            $display("FAIL proto_done_addr: got addr=%0d busy=%0d required 0 0", addr_c, busy_c);
        end
    endtask

    task automatic test_primary_colours();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            exp = (i < 4) ? bg(i) : (i < 7) ? 8'd76 : (i < 10) ? 8'd149 : (i < 13) ? 8'd28 : 8'd0;
            n_checks++;
            if (mem_c[i] !== exp) begin
                n_fail++;
                $display("FAIL primary_byte%0d: got %0d required %0d", i, mem_c[i], exp);
            end
        end
    endtask

    task automatic test_reset_midway();
        int n;
        logic [7:0] exp;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fill_bg();
        img[4] = 8'd100; img[5] = 8'd150; img[6] = 8'd200;
        img[7] = 8'd0;   img[8] = 8'd0;   img[9] = 8'd255;
        load(0);
        @(negedge clk);
        iv_a = 1'b1;
        @(posedge clk);
        #1;
        iv_a = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        n_checks++;
        if (wen_a !== 1'b1 || addr_a !== 20'd8) begin
            n_fail++;
            $display("FAIL midreset_in_wr_g: got wen=%0d addr=%0d required 1 8", wen_a, addr_a);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ren_a, wen_a, din_a, addr_a, done_a, busy_a} !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ren=%0d wen=%0d in=%0d addr=%0d done=%0d busy=%0d required all 0",
                     ren_a, wen_a, din_a, addr_a, done_a, busy_a);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 4; i < 10; i++) begin
            exp = (i < 7) ? 8'd159 : (i == 7) ? 8'd76 : (i == 8) ? 8'd0 : 8'd255;
            n_checks++;
            if (mem_a[i] !== exp) begin
                n_fail++;
                $display("FAIL midreset_partial_byte%0d: got %0d required %0d", i, mem_a[i], exp);
            end
        end
        run_and_time(0, n);
        n_checks++;
        if (n !== 15) begin
            n_fail++;
            $display("FAIL rerun_done_latency: got %0d cycles required 15", n);
        end
        // Pixel 1 now starts from B=76,G=0,R=255 left by the aborted pass.
        for (int i = 0; i < 10; i++) begin
            exp = (i < 4) ? bg(i) : (i < 7) ? 8'd159 : 8'd85;
            n_checks++;
            if (mem_a[i] !== exp) begin
                n_fail++;
                $display("FAIL rerun_byte%0d: got %0d required %0d", i, mem_a[i], exp);
            end
        end
    endtask

    task automatic test_after_done();
        logic [7:0] exp;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_checks++;
            if (ren_a !== 1'b0 || wen_a !== 1'b0 || done_a !== 1'b1 || busy_a !== 1'b0
                || addr_a !== 20'd0) begin
                n_fail++;
                $display("FAIL after_done_c%0d: got ren=%0d wen=%0d done=%0d busy=%0d addr=%0d required 0 0 1 0 0",
                         c, ren_a, wen_a, done_a, busy_a, addr_a);
            end
            iv_a = ~iv_a;
        end
        iv_a = 1'b0;
        for (int i = 4; i < 10; i++) begin
            exp = (i < 7) ? 8'd159 : 8'd85;
            n_checks++;
            if (mem_a[i] !== exp) begin
                n_fail++;
                $display("FAIL after_done_byte%0d: got %0d required %0d", i, mem_a[i], exp);
            end
        end
    endtask

    initial begin
        iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
        ld_a = 1'b0; ld_b = 1'b0; ld_c = 1'b0;
        for (int i = 0; i < 16; i++) img[i] = 8'd0;
        test_reset();
        test_small_image();
        test_non_multiple();
        test_protocol();
        test_primary_colours();
        test_reset_midway();
        test_after_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
